// File: rtl/switch_control_pkg.sv
// Shared constants, FSM/drain encodings and XY routing helper for the Phoenix switch control.
package switch_control_pkg;

  localparam int unsigned TAM_FLIT = 16;

  localparam logic [2:0] EAST  = 3'd0;
  localparam logic [2:0] WEST  = 3'd1;
  localparam logic [2:0] NORTH = 3'd2;
  localparam logic [2:0] SOUTH = 3'd3;
  localparam logic [2:0] LOCAL = 3'd4;

  localparam int unsigned X_MSB = 7;
  localparam int unsigned X_LSB = 4;
  localparam int unsigned Y_MSB = 3;
  localparam int unsigned Y_LSB = 0;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ROUTE, S_CHECK} state_t;
  typedef enum logic [1:0] {PH_HDR, PH_SIZE, PH_PAYLOAD} phase_t;

  // X is resolved before Y; equal coordinates deliver locally.
  function automatic logic [2:0] xy_route(input logic [7:0] hdr, input logic [7:0] addr);
    if (hdr[X_MSB:X_LSB] > addr[X_MSB:X_LSB]) return EAST;
    if (hdr[X_MSB:X_LSB] < addr[X_MSB:X_LSB]) return WEST;
    if (hdr[Y_MSB:Y_LSB] > addr[Y_MSB:Y_LSB]) return NORTH;
    if (hdr[Y_MSB:Y_LSB] < addr[Y_MSB:Y_LSB]) return SOUTH;
    return LOCAL;
  endfunction

endpackage

// File: rtl/rr_arbiter_5.sv
// Combinational round-robin pick over five requesters, starting just after ptr.
module rr_arbiter_5 (
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [2:0] grant,
  output logic       valid
);

  logic [2:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= 5; i++) begin
      idx = 3'((int'(ptr) + i) % 5);
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/switch_control.sv
// Phoenix router allocator: round-robin header pick, XY route, output allocation, drain tracking.
// Optional SWC_STATS_EN adds o_pkt_cnt, a wrapping count of granted headers.
module switch_control
  import switch_control_pkg::*;
#(
  parameter int unsigned WIDTH = TAM_FLIT,
  parameter logic [7:0]  ADDR  = 8'h00,
  parameter int unsigned NPORT = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NPORT-1:0]       i_req,
  input  logic [NPORT*WIDTH-1:0] i_head,
  input  logic [NPORT-1:0]       i_sent,
  output logic [NPORT-1:0]       o_ack_h,
  output logic [NPORT*3-1:0]     o_sel,
  output logic [NPORT-1:0]       o_busy,
`ifdef SWC_STATS_EN
  output logic [15:0]            o_pkt_cnt,
`endif
  output logic [NPORT-1:0]       o_conn
);

  state_t           state, state_next;
  logic [2:0]       rr_ptr, cur, out;
  logic [7:0]       hdr;
  phase_t           phase    [NPORT];
  logic [WIDTH-1:0] rem      [NPORT];
  logic [2:0]       port_out [NPORT];
  logic [NPORT-1:0] pending, releases, freed, granted_in, granted_out;
  logic [2:0]       arb_grant;
  logic             arb_valid, grant_now;

  assign pending = i_req & ~o_conn;

  rr_arbiter_5 u_arb (
    .req  (pending),
    .ptr  (rr_ptr),
    .grant(arb_grant),
    .valid(arb_valid)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (|pending) state_next = S_ARB;
      S_ARB:   state_next = arb_valid ? S_ROUTE : S_IDLE;
      S_ROUTE: state_next = S_CHECK;
      S_CHECK: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Registered busy is used, so an output freed this cycle is not reusable until the next round.
  assign grant_now = (state == S_CHECK) && !o_busy[out];

  always_comb begin
    granted_in  = '0;
    granted_out = '0;
    if (grant_now) begin
      granted_in[cur]  = 1'b1;
      granted_out[out] = 1'b1;
    end
  end

  always_comb begin
    releases = '0;
    freed    = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (o_conn[p] && i_sent[p]) begin
        if (phase[p] == PH_SIZE && i_head[p*WIDTH +: WIDTH] == '0) releases[p] = 1'b1;
        if (phase[p] == PH_PAYLOAD && rem[p] == WIDTH'(1)) releases[p] = 1'b1;
      end
      if (releases[p]) freed[port_out[p]] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state   <= S_IDLE;
      rr_ptr  <= 3'd4;
      cur     <= '0;
      out     <= '0;
      hdr     <= '0;
      o_ack_h <= '0;
      o_sel   <= '0;
      o_busy  <= '0;
      o_conn  <= '0;
      for (int p = 0; p < NPORT; p++) begin
        phase[p]    <= PH_HDR;
        rem[p]      <= '0;
        port_out[p] <= '0;
      end
    end else begin
      state   <= state_next;
      o_ack_h <= granted_in;
      o_busy  <= (o_busy & ~freed) | granted_out;
      o_conn  <= (o_conn & ~releases) | granted_in;
      if (state == S_ARB && arb_valid) begin
        cur    <= arb_grant;
        rr_ptr <= arb_grant;
        hdr    <= i_head[int'(arb_grant)*WIDTH +: 8];
      end
      if (state == S_ROUTE) out <= xy_route(hdr, ADDR);
      for (int p = 0; p < NPORT; p++) begin
        if (o_conn[p] && i_sent[p]) begin
          unique case (phase[p])
            PH_HDR:  phase[p] <= PH_SIZE;
            PH_SIZE: begin
              rem[p]   <= i_head[p*WIDTH +: WIDTH];
              phase[p] <= PH_PAYLOAD;
            end
            PH_PAYLOAD: rem[p] <= rem[p] - WIDTH'(1);
            default:    phase[p] <= PH_HDR;
          endcase
        end
      end
      if (grant_now) begin
        o_sel[int'(out)*3 +: 3] <= cur;
        port_out[cur]           <= out;
        phase[cur]              <= PH_HDR;
      end
    end
  end

`ifdef SWC_STATS_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst) o_pkt_cnt <= '0;
    else if (grant_now) o_pkt_cnt <= o_pkt_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_switch_control.sv
// Self-checking bench for switch_control: directed scenarios plus randomized traffic
// against a packet-level reference model (owner table, flit counts, round-robin scan).
module tb_switch_control;

  localparam int W = 16;
  localparam logic [7:0] ADDR = 8'h22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [4:0]     req, sent, ack, busy, conn;
  logic [5*W-1:0] head;
  logic [14:0]    sel;
`ifdef SWC_STATS_EN
  logic [15:0]    pkt_cnt;
`endif

  switch_control #(.WIDTH(W), .ADDR(ADDR), .NPORT(5)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_req  (req),
    .i_head (head),
    .i_sent (sent),
    .o_ack_h(ack),
    .o_sel  (sel),
    .o_busy (busy),
`ifdef SWC_STATS_EN
    .o_pkt_cnt(pkt_cnt),
`endif
    .o_conn (conn)
  );

  int tests = 0;
  int fails = 0;

  int q_hdr [5][$];
  int q_size[5][$];
  int ack_log[$];
  int sent_pct;
  bit noise;
  logic rst_drive;

  int m_owner[5], m_dst[5], m_cnt[5], m_total[5];
  logic [4:0] m_conn, m_ack;
  int m_ptr, m_step, m_cur, m_dcur, m_pkts;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int route(input logic [7:0] h);
    int dx, dy, ax, ay;
    dx = int'(h[7:4]);
    dy = int'(h[3:0]);
    ax = int'(ADDR[7:4]);
    ay = int'(ADDR[3:0]);
    if (dx > ax) return 0;
    if (dx < ax) return 1;
    if (dy > ay) return 2;
    if (dy < ay) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 5; p++) begin
      m_owner[p] = -1;
      m_dst[p]   = 0;
      m_cnt[p]   = 0;
      m_total[p] = 0;
    end
    m_conn = '0;
    m_ack  = '0;
    m_ptr  = 4;
    m_step = 0;
    m_cur  = 0;
    m_dcur = 0;
    m_pkts = 0;
  endtask

  task automatic clear_queues();
    for (int p = 0; p < 5; p++) begin
      q_hdr[p].delete();
      q_size[p].delete();
    end
  endtask

  task automatic push(input int p, input int h, input int s);
    q_hdr[p].push_back(h);
    q_size[p].push_back(s);
  endtask

  // Packet finishes after header + size flit + 'size' payload flits.
  task automatic model_step();
    logic [4:0] conn_pre;
    bit do_grant;
    logic [7:0] h;
    if (rst !== 1'b1) begin
      model_reset();
      return;
    end
    conn_pre = m_conn;
    m_ack    = '0;
    do_grant = (m_step == 3) && (m_owner[m_dcur] < 0);
    for (int p = 0; p < 5; p++) begin
      if (conn_pre[p] && sent[p]) begin
        m_cnt[p]++;
        if (m_cnt[p] == 2) m_total[p] = int'(head[p*W +: W]) + 2;
        if (m_cnt[p] >= 2 && m_cnt[p] == m_total[p]) begin
          m_owner[m_dst[p]] = -1;
          m_conn[p] = 1'b0;
          m_cnt[p]  = 0;
          void'(q_hdr[p].pop_front());
          void'(q_size[p].pop_front());
        end
      end
    end
    if (do_grant) begin
      m_owner[m_dcur] = m_cur;
      m_dst[m_cur]    = m_dcur;
      m_conn[m_cur]   = 1'b1;
      m_ack[m_cur]    = 1'b1;
      m_cnt[m_cur]    = 0;
      m_pkts++;
    end
    case (m_step)
      0: if ((req & ~conn_pre) != 5'd0) m_step = 1;
      1: begin
        m_step = 0;
        for (int k = 1; k <= 5; k++) begin
          int pp;
          pp = (m_ptr + k) % 5;
          if (m_step == 0 && req[pp] && !conn_pre[pp]) begin
            m_cur  = pp;
            m_ptr  = pp;
            h      = head[pp*W +: 8];
            m_dcur = route(h);
            m_step = 2;
          end
        end
      end
      2: m_step = 3;
      default: m_step = 0;
    endcase
  endtask

  task automatic drive();
    for (int p = 0; p < 5; p++) begin
      if (m_conn[p]) begin
        req[p] = 1'b0;
        if (m_cnt[p] == 0) head[p*W +: W] = W'(q_hdr[p][0]);
        else if (m_cnt[p] == 1) head[p*W +: W] = W'(q_size[p][0]);
        else head[p*W +: W] = W'($urandom);
        sent[p] = ($urandom_range(1, 100) <= sent_pct);
      end else begin
        req[p] = (q_hdr[p].size() > 0);
        head[p*W +: W] = (q_hdr[p].size() > 0) ? W'(q_hdr[p][0]) : W'($urandom);
        sent[p] = noise && ($urandom_range(0, 7) == 0);
      end
    end
  endtask

  task automatic cycle();
    logic [4:0] mb;
    @(negedge clk);
    rst = rst_drive;
    drive();
    @(posedge clk);
    #1;
    model_step();
    mb = '0;
    for (int q = 0; q < 5; q++) if (m_owner[q] >= 0) mb[q] = 1'b1;
    chk("ack_h", 32'(ack), 32'(m_ack));
    chk("conn", 32'(conn), 32'(m_conn));
    chk("busy", 32'(busy), 32'(mb));
    for (int q = 0; q < 5; q++)
      if (m_owner[q] >= 0) chk($sformatf("sel%0d", q), 32'(sel[q*3 +: 3]), m_owner[q]);
`ifdef SWC_STATS_EN
    chk("pkt_cnt", 32'(pkt_cnt), m_pkts & 32'hFFFF);
`endif
    for (int p = 0; p < 5; p++) if (ack[p] === 1'b1) ack_log.push_back(p);
  endtask

  task automatic wait_ack(input int p, output int n);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      cycle();
      if (ack[p] === 1'b1) begin
        n = i;
        break;
      end
    end
    chk($sformatf("ack_wait_p%0d", p), 32'(n != 0), 32'd1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      cycle();
      done = (m_conn == 5'd0) && (m_step == 0);
      for (int p = 0; p < 5; p++) if (q_hdr[p].size() > 0) done = 1'b0;
    end
    chk("drain_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int n;
    int h;
    req = '0; sent = '0; head = '0; rst = 1'b0;
    rst_drive = 1'b0; sent_pct = 0; noise = 1'b0;
    model_reset();
    clear_queues();

    // Reset state
    cycle();
    cycle();
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_conn", 32'(conn), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    rst_drive = 1'b1;
    cycle();

    // Single eastbound header on port 4: four-cycle latency
    push(4, 16'hA532, 1);
    wait_ack(4, n);
    chk("t1_latency", n, 4);
    chk("t1_busy0", 32'(busy[0]), 32'd1);
    chk("t1_sel0", 32'(sel[2:0]), 32'd4);
    sent_pct = 100;
    drain();

    // Ports 0 and 1 contend for LOCAL; 1 waits for 0's drain
    ack_log.delete();
    push(0, 16'h0022, 2);
    push(1, 16'h0022, 2);
    drain();
    chk("t2_count", ack_log.size(), 2);
    chk("t2_first", ack_log[0], 0);
    chk("t2_second", ack_log[1], 1);

    // Zero-size packet releases on the second strobe
    push(2, 16'h0022, 0);
    sent_pct = 0;
    wait_ack(2, n);
    sent_pct = 100;
    cycle();
    chk("t3_hold", 32'(conn[2]), 32'd1);
    cycle();
    chk("t3_conn_rel", 32'(conn[2]), 32'd0);
    chk("t3_busy_rel", 32'(busy[4]), 32'd0);
    drain();

    // Bring the pointer to 4, then ports 0,2,3 to distinct outputs
    push(4, 16'h0022, 0);
    drain();
    sent_pct = 0;
    ack_log.delete();
    push(0, 16'h0032, 1);
    push(2, 16'h0012, 1);
    push(3, 16'h0023, 1);
    for (int i = 0; i < 100 && ack_log.size() < 3; i++) cycle();
    chk("t4_count", ack_log.size(), 3);
    chk("t4_g0", ack_log[0], 0);
    chk("t4_g1", ack_log[1], 2);
    chk("t4_g2", ack_log[2], 3);
    push(1, 16'h0022, 1);
    push(4, 16'h0021, 1);
    for (int i = 0; i < 100 && ack_log.size() < 5; i++) cycle();
    chk("t4_count2", ack_log.size(), 5);
    chk("t4_wrap", ack_log[3], 4);
    chk("t4_after", ack_log[4], 1);
    sent_pct = 100;
    drain();

    // Reset mid-payload drops everything
    push(1, 16'h0022, 5);
    sent_pct = 0;
    wait_ack(1, n);
    sent_pct = 100;
    cycle();
    cycle();
    cycle();
    rst_drive = 1'b0;
    cycle();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_conn", 32'(conn), 32'd0);
    chk("t5_ack", 32'(ack), 32'd0);
    chk("t5_sel", 32'(sel), 32'd0);
    clear_queues();
    rst_drive = 1'b1;
    cycle();
    push(3, 16'h0023, 1);
    wait_ack(3, n);
    chk("t5_relatency", n, 4);
    drain();

    // Randomized traffic
    noise = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) sent_pct = $urandom_range(0, 100);
      for (int p = 0; p < 5; p++) begin
        if (q_hdr[p].size() < 2 && $urandom_range(0, 9) == 0) begin
          h = {16'd0, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 4)),
               4'($urandom_range(0, 4))};
          push(p, h, $urandom_range(0, 3));
        end
      end
      cycle();
    end
    noise = 1'b0;
    sent_pct = 100;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
